// File: rtl/nand_cpu_pkg.sv
// Shared types for the nand_cpu core: memory operation codes and
// the arbiter's FSM state and ownership encodings.
package nand_cpu_pkg;

    typedef enum logic {
        READ  = 1'b0,
        WRITE = 1'b1
    } MEM_OP;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_REQ,
        ARB_RESP
    } ARB_STATE;

    typedef enum logic {
        OWN_FETCH,
        OWN_DATA
    } ARB_OWNER;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Single-ported memory bus: the arbiter is the master,
// the memory is the slave.
interface mem_port_arbiter_if
    import nand_cpu_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);

    logic              mem_req;
    MEM_OP             mem_op;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_op,
        output mem_addr,
        output mem_wdata,
        input  mem_ack,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_op,
        input  mem_addr,
        input  mem_wdata,
        output mem_ack,
        output mem_rdata
    );

endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one variable-latency memory port between fetch and load/store,
// data first, with a bounded data streak so fetch cannot starve.
module mem_port_arbiter
    import nand_cpu_pkg::*;
#(
    parameter int ADDR_W       = 8,
    parameter int DATA_W       = 8,
    parameter int MAX_D_STREAK = 4,
    parameter int TIMEOUT      = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_done,
    output logic [DATA_W-1:0] f_rdata,
    input  logic              d_req,
    input  MEM_OP             d_op,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_done,
    output logic [DATA_W-1:0] d_rdata,
    mem_port_arbiter_if.master mem,
    output logic              err,
    output logic              busy
);

    localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam bit T_EN = (TIMEOUT != 0);
    localparam logic [TW-1:0] T_LAST = TW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
    localparam logic [3:0] S_MAX = 4'(MAX_D_STREAK);

    ARB_STATE          state_q, state_d;
    ARB_OWNER          owner_q, owner_d;
    logic [3:0]        streak_q, streak_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic              req_q, req_d;
    MEM_OP             op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              f_done_d, d_done_d, err_d, busy_d;
    logic [DATA_W-1:0] f_rdata_d, d_rdata_d, rd;
    logic              grant_data;

    assign grant_data = d_req && !(f_req && streak_q == S_MAX);
    assign rd = (op_q == WRITE) ? '0 : mem.mem_rdata;

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        streak_d  = streak_q;
        timer_d   = timer_q;
        req_d     = req_q;
        op_d      = op_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        f_done_d  = 1'b0;
        d_done_d  = 1'b0;
        f_rdata_d = '0;
        d_rdata_d = '0;
        err_d     = 1'b0;
        unique case (state_q)
            ARB_IDLE: begin
                if (f_req || d_req) begin
                    req_d   = 1'b1;
                    timer_d = '0;
                    state_d = ARB_REQ;
                    if (grant_data) begin
                        owner_d = OWN_DATA;
                        op_d    = d_op;
                        addr_d  = d_addr;
                        wdata_d = d_wdata;
                        if (!f_req)
                            streak_d = '0;
                        else if (streak_q != S_MAX)
                            streak_d = streak_q + 4'd1;
                    end else begin
                        owner_d  = OWN_FETCH;
                        op_d     = READ;
                        addr_d   = f_addr;
                        wdata_d  = '0;
                        streak_d = '0;
                    end
                end
            end
            ARB_REQ: begin
                timer_d = timer_q + TW'(1);
                // An ack on the deadline cycle still wins over the timeout.
                if (mem.mem_ack) begin
                    req_d    = 1'b0;
                    state_d  = ARB_RESP;
                    f_done_d = (owner_q == OWN_FETCH);
                    d_done_d = (owner_q == OWN_DATA);
                    if (owner_q == OWN_DATA)
                        d_rdata_d = rd;
                    else
                        f_rdata_d = rd;
                end else if (T_EN && timer_q == T_LAST) begin
                    req_d    = 1'b0;
                    state_d  = ARB_RESP;
                    err_d    = 1'b1;
                    f_done_d = (owner_q == OWN_FETCH);
                    d_done_d = (owner_q == OWN_DATA);
                end
            end
            ARB_RESP: begin
                state_d = ARB_IDLE;
                timer_d = '0;
            end
            default: state_d = ARB_IDLE;
        endcase
        busy_d = (state_d != ARB_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ARB_IDLE;
            owner_q  <= OWN_FETCH;
            streak_q <= '0;
            timer_q  <= '0;
            req_q    <= 1'b0;
            op_q     <= READ;
            addr_q   <= '0;
            wdata_q  <= '0;
            f_done   <= 1'b0;
            d_done   <= 1'b0;
            f_rdata  <= '0;
            d_rdata  <= '0;
            err      <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            streak_q <= streak_d;
            timer_q  <= timer_d;
            req_q    <= req_d;
            op_q     <= op_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            f_done   <= f_done_d;
            d_done   <= d_done_d;
            f_rdata  <= f_rdata_d;
            d_rdata  <= d_rdata_d;
            err      <= err_d;
            busy     <= busy_d;
        end
    end

    assign mem.mem_req   = req_q;
    assign mem.mem_op    = op_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = wdata_q;

    // The granted requester must keep its request up while memory is busy.
    owner_holds_req: assert property (
        @(posedge clk) disable iff (rst)
        (state_q == ARB_REQ) |-> ((owner_q == OWN_DATA) ? d_req : f_req)
    );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized and directed bench for mem_port_arbiter against a
// transaction-level model of the grant, streak and timeout rules.
module tb_mem_port_arbiter;
    import nand_cpu_pkg::*;

    localparam int MAXS = 4;
    localparam int TOUT = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       f_req;
    logic [7:0] f_addr;
    logic       f_done;
    logic [7:0] f_rdata;
    logic       d_req;
    MEM_OP      d_op;
    logic [7:0] d_addr;
    logic [7:0] d_wdata;
    logic       d_done;
    logic [7:0] d_rdata;
    logic       err;
    logic       busy;

    int checks = 0;
    int failures = 0;
    int streak_m = 0;

    mem_port_arbiter_if #(.ADDR_W(8), .DATA_W(8)) mif ();

    mem_port_arbiter #(
        .ADDR_W(8),
        .DATA_W(8),
        .MAX_D_STREAK(MAXS),
        .TIMEOUT(TOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .f_req(f_req),
        .f_addr(f_addr),
        .f_done(f_done),
        .f_rdata(f_rdata),
        .d_req(d_req),
        .d_op(d_op),
        .d_addr(d_addr),
        .d_wdata(d_wdata),
        .d_done(d_done),
        .d_rdata(d_rdata),
        .mem(mif),
        .err(err),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full transaction starting in IDLE with requests already driven.
    // w < 0 means memory never acks; returns whether data won the grant.
    task automatic txn(input int w, input logic [7:0] rd, output bit gd);
        MEM_OP      e_op;
        logic [7:0] e_addr, e_wd, e_rd;
        int         n;
        gd = d_req && !(f_req && streak_m == MAXS);
        if (gd && f_req)
            streak_m = (streak_m == MAXS) ? MAXS : streak_m + 1;
        else
            streak_m = 0;
        e_op   = gd ? d_op : READ;
        e_addr = gd ? d_addr : f_addr;
        e_wd   = gd ? d_wdata : 8'h00;
        e_rd   = (w < 0 || (gd && d_op == WRITE)) ? 8'h00 : rd;
        n      = (w < 0) ? TOUT : w + 1;
        mif.mem_ack = 1'($urandom_range(0, 1));
        tick();
        for (int i = 0; i < n; i++) begin
            check("req_hi", 32'(mif.mem_req), 32'd1);
            check("req_op", 32'(mif.mem_op), 32'(e_op));
            check("req_addr", 32'(mif.mem_addr), 32'(e_addr));
            check("req_wdata", 32'(mif.mem_wdata), 32'(e_wd));
            check("req_busy", 32'(busy), 32'd1);
            check("req_nodone", 32'({f_done, d_done, err}), 32'd0);
            if (w >= 0 && i == w) begin
                mif.mem_ack   = 1'b1;
                mif.mem_rdata = rd;
            end else begin
                mif.mem_ack   = 1'b0;
                mif.mem_rdata = 8'($urandom);
            end
            tick();
        end
        mif.mem_ack   = 1'($urandom_range(0, 1));
        mif.mem_rdata = 8'($urandom);
        check("resp_fdone", 32'(f_done), 32'(!gd));
        check("resp_ddone", 32'(d_done), 32'(gd));
        check("resp_frdata", 32'(f_rdata), gd ? 32'd0 : 32'(e_rd));
        check("resp_drdata", 32'(d_rdata), gd ? 32'(e_rd) : 32'd0);
        check("resp_err", 32'(err), 32'(w < 0));
        check("resp_req", 32'(mif.mem_req), 32'd0);
        check("resp_busy", 32'(busy), 32'd1);
        if (gd)
            d_req = 1'b0;
        else
            f_req = 1'b0;
        tick();
        mif.mem_ack = 1'b0;
        check("idle_done", 32'({f_done, d_done, err}), 32'd0);
        check("idle_rdata", 32'({f_rdata, d_rdata}), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        bit         gd;
        logic [9:0] pat;
        rst = 1'b1;
        f_req = 1'b0;
        f_addr = '0;
        d_req = 1'b0;
        d_op = READ;
        d_addr = '0;
        d_wdata = '0;
        mif.mem_ack = 1'b0;
        mif.mem_rdata = '0;
        tick();
        tick();
        check("rst_fdone", 32'(f_done), 32'd0);
        check("rst_ddone", 32'(d_done), 32'd0);
        check("rst_rdata", 32'({f_rdata, d_rdata}), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_req", 32'(mif.mem_req), 32'd0);
        check("rst_op", 32'(mif.mem_op), 32'(READ));
        check("rst_bus", 32'({mif.mem_addr, mif.mem_wdata}), 32'd0);
        rst = 1'b0;
        tick();

        f_req = 1'b1;
        f_addr = 8'h10;
        txn(0, 8'hA5, gd);
        check("fetch_grant", 32'(gd), 32'd0);

        d_req = 1'b1;
        d_op = WRITE;
        d_addr = 8'h20;
        d_wdata = 8'h3C;
        txn(3, 8'hEE, gd);
        check("store_grant", 32'(gd), 32'd1);

        pat = 10'b1111011110;
        for (int i = 0; i < 10; i++) begin
            if (!f_req) begin
                f_req = 1'b1;
                f_addr = 8'(8'h40 + i);
            end
            if (!d_req) begin
                d_req = 1'b1;
                d_op = READ;
                d_addr = 8'(8'h80 + i);
            end
            txn(0, 8'(i * 17), gd);
            check($sformatf("streak_order%0d", i), 32'(gd), 32'(pat[9 - i]));
        end
        d_req = 1'b0;

        f_req = 1'b1;
        f_addr = 8'h55;
        txn(-1, 8'h99, gd);
        d_req = 1'b1;
        d_op = READ;
        d_addr = 8'h33;
        txn(1, 8'h77, gd);

        d_req = 1'b1;
        d_op = READ;
        d_addr = 8'h61;
        tick();
        check("abort_req", 32'(mif.mem_req), 32'd1);
        tick();
        rst = 1'b1;
        tick();
        check("abort_out", 32'({f_done, d_done, err, busy, mif.mem_req}), 32'd0);
        check("abort_rdata", 32'({f_rdata, d_rdata}), 32'd0);
        d_req = 1'b0;
        rst = 1'b0;
        streak_m = 0;
        tick();
        check("abort_nodone", 32'({f_done, d_done, err, busy}), 32'd0);
        f_req = 1'b1;
        f_addr = 8'h0F;
        txn(2, 8'h5A, gd);

        for (int it = 0; it < 80; it++) begin
            if (!f_req && $urandom_range(0, 1) == 1) begin
                f_req = 1'b1;
                f_addr = 8'($urandom);
            end
            if (!d_req && $urandom_range(0, 1) == 1) begin
                d_req = 1'b1;
                d_op = MEM_OP'($urandom_range(0, 1));
                d_addr = 8'($urandom);
                d_wdata = 8'($urandom);
            end
            if (!f_req && !d_req) begin
                mif.mem_ack = 1'($urandom_range(0, 1));
                tick();
                mif.mem_ack = 1'b0;
                check("rnd_idle", 32'({busy, mif.mem_req, f_done, d_done}), 32'd0);
            end else begin
                txn(($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 3)),
                    8'($urandom), gd);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
